// File: rtl/vend_ctrl.sv
// Vending-machine transaction controller: BCD credit accumulation, price lookup,
// purchase validation and change computation feeding the seven-segment driver.
module vend_ctrl #(
  parameter logic [7:0]  PRICE0      = 8'h15,
  parameter logic [7:0]  PRICE1      = 8'h25,
  parameter logic [7:0]  PRICE2      = 8'h30,
  parameter logic [7:0]  PRICE3      = 8'h45,
  parameter int unsigned HOLD_CYCLES = 32'd50_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        coin_1,
  input  logic        coin_5,
  input  logic        coin_10,
  input  logic [1:0]  goods_sel,
  input  logic        buy,
  input  logic        cancel,
  output logic [7:0]  goods_money,
  output logic [11:0] money,
  output logic [11:0] small_change,
  output logic [1:0]  state,
  output logic        dispense,
  output logic [1:0]  goods_out,
  output logic        coin_reject,
  output logic        buy_err
);

  typedef enum logic [1:0] {
    IDLE   = 2'b01,
    PAY    = 2'b10,
    VEND   = 2'b11,
    CHANGE = 2'b00
  } state_t;

  state_t      st_q, st_d;
  logic [11:0] money_q, money_d, change_q, change_d;
  logic [7:0]  gm_q, gm_d;
  logic [1:0]  gout_q, gout_d, sel_q, sel_d;
  logic        disp_q, disp_d, rej_q, rej_d, err_q, err_d;
  logic [31:0] cnt_q, cnt_d;

  logic        any_coin;
  logic [3:0]  coin_ones;
  logic [7:0]  coin_bcd;
  logic        add_carry;
  logic [11:0] add_sum;

  function automatic logic [7:0] price_of(input logic [1:0] s);
    case (s)
      2'd0:    return PRICE0;
      2'd1:    return PRICE1;
      2'd2:    return PRICE2;
      default: return PRICE3;
    endcase
  endfunction

  // Returns {carry_out, sum}; a carry out means the credit would exceed 999.
  function automatic logic [12:0] bcd_add(input logic [11:0] a, input logic [7:0] b);
    logic [11:0] bb, r;
    logic [4:0]  t;
    logic        c;
    bb = {4'h0, b};
    r  = '0;
    c  = 1'b0;
    for (int unsigned i = 0; i < 3; i++) begin
      t = {1'b0, a[i*4 +: 4]} + {1'b0, bb[i*4 +: 4]} + {4'b0, c};
      if (t > 5'd9) begin
        t = t - 5'd10;
        c = 1'b1;
      end else begin
        c = 1'b0;
      end
      r[i*4 +: 4] = t[3:0];
    end
    return {c, r};
  endfunction

  // 5-bit modular digit difference; bit 4 flags a borrow, +10 restores the digit.
  function automatic logic [11:0] bcd_sub(input logic [11:0] a, input logic [7:0] b);
    logic [11:0] bb, r;
    logic [4:0]  t;
    logic        br;
    bb = {4'h0, b};
    r  = '0;
    br = 1'b0;
    for (int unsigned i = 0; i < 3; i++) begin
      t = {1'b0, a[i*4 +: 4]} - {1'b0, bb[i*4 +: 4]} - {4'b0, br};
      if (t[4]) begin
        t  = t + 5'd10;
        br = 1'b1;
      end else begin
        br = 1'b0;
      end
      r[i*4 +: 4] = t[3:0];
    end
    return r;
  endfunction

  assign any_coin  = coin_1 | coin_5 | coin_10;
  assign coin_ones = {3'b000, coin_1} + (coin_5 ? 4'd5 : 4'd0);
  assign coin_bcd  = {3'b000, coin_10, coin_ones};
  assign {add_carry, add_sum} = bcd_add(money_q, coin_bcd);

  always_comb begin
    st_d     = st_q;
    money_d  = money_q;
    change_d = change_q;
    gm_d     = gm_q;
    gout_d   = gout_q;
    sel_d    = sel_q;
    cnt_d    = cnt_q;
    disp_d   = 1'b0;
    rej_d    = 1'b0;
    err_d    = 1'b0;
    case (st_q)
      IDLE: begin
        gm_d = price_of(goods_sel);
        if (any_coin) begin
          if (add_carry) begin
            rej_d = 1'b1;
          end else begin
            money_d = add_sum;
            st_d    = PAY;
          end
        end
      end
      PAY: begin
        gm_d = price_of(goods_sel);
        if (cancel) begin
          change_d = money_q;
          money_d  = '0;
          rej_d    = any_coin;
          cnt_d    = '0;
          st_d     = CHANGE;
        end else if (any_coin) begin
          if (add_carry) rej_d = 1'b1;
          else           money_d = add_sum;
        end else if (buy) begin
          // Packed BCD orders the same as binary, so a plain compare suffices.
          if (money_q >= {4'h0, price_of(goods_sel)}) begin
            sel_d  = goods_sel;
            gout_d = goods_sel;
            disp_d = 1'b1;
            st_d   = VEND;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      VEND: begin
        rej_d    = any_coin;
        change_d = bcd_sub(money_q, price_of(sel_q));
        money_d  = '0;
        cnt_d    = '0;
        st_d     = CHANGE;
      end
      default: begin
        rej_d = any_coin;
        if (cnt_q == HOLD_CYCLES - 1) begin
          change_d = '0;
          cnt_d    = '0;
          st_d     = IDLE;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st_q     <= IDLE;
      money_q  <= '0;
      change_q <= '0;
      gm_q     <= PRICE0;
      gout_q   <= '0;
      sel_q    <= '0;
      cnt_q    <= '0;
      disp_q   <= 1'b0;
      rej_q    <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      st_q     <= st_d;
      money_q  <= money_d;
      change_q <= change_d;
      gm_q     <= gm_d;
      gout_q   <= gout_d;
      sel_q    <= sel_d;
      cnt_q    <= cnt_d;
      disp_q   <= disp_d;
      rej_q    <= rej_d;
      err_q    <= err_d;
    end
  end

  assign state        = st_q;
  assign money        = money_q;
  assign small_change = change_q;
  assign goods_money  = gm_q;
  assign goods_out    = gout_q;
  assign dispense     = disp_q;
  assign coin_reject  = rej_q;
  assign buy_err      = err_q;

endmodule

// File: tb/tb_vend_ctrl.sv
// Self-checking bench for vend_ctrl: a vector table for the main flows plus
// hand-written sequences for carry, saturation, cancel races and reset in VEND.
module tb_vend_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        coin_1, coin_5, coin_10, buy, cancel;
  logic [1:0]  goods_sel;
  logic [7:0]  goods_money;
  logic [11:0] money, small_change;
  logic [1:0]  state, goods_out;
  logic        dispense, coin_reject, buy_err;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  vend_ctrl #(.HOLD_CYCLES(8)) dut (
    .clk(clk), .rst(rst),
    .coin_1(coin_1), .coin_5(coin_5), .coin_10(coin_10),
    .goods_sel(goods_sel), .buy(buy), .cancel(cancel),
    .goods_money(goods_money), .money(money), .small_change(small_change),
    .state(state), .dispense(dispense), .goods_out(goods_out),
    .coin_reject(coin_reject), .buy_err(buy_err)
  );

  typedef struct {
    logic        c1, c5, c10;
    logic [1:0]  sel;
    logic        b, cn;
    logic [1:0]  st;
    logic [11:0] m, ch;
    logic [7:0]  gm;
    logic        disp;
    logic [1:0]  gout;
    logic        rej, err;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(input logic c1, c5, c10, input logic [1:0] sel,
                              input logic b, cn, input logic [1:0] st,
                              input logic [11:0] m, ch, input logic [7:0] gm,
                              input logic disp, input logic [1:0] gout,
                              input logic rej, err);
    vec_t v;
    v.c1 = c1; v.c5 = c5; v.c10 = c10; v.sel = sel; v.b = b; v.cn = cn;
    v.st = st; v.m = m; v.ch = ch; v.gm = gm; v.disp = disp; v.gout = gout;
    v.rej = rej; v.err = err;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step(input logic c1, c5, c10, input logic [1:0] sel, input logic b, cn);
    @(negedge clk);
    coin_1 = c1; coin_5 = c5; coin_10 = c10; goods_sel = sel; buy = b; cancel = cn;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input string name);
    int unsigned n;
    n = 0;
    while (state !== 2'b01 && n < 20) begin
      step(0, 0, 0, goods_sel, 0, 0);
      n++;
    end
    chk(name, {30'd0, state}, 32'h1);
  endtask

  initial begin
    rst = 1'b0;
    coin_1 = 0; coin_5 = 0; coin_10 = 0; buy = 0; cancel = 0; goods_sel = 2'd0;

    // Item 2 purchase with 5 change, then the 8-cycle hold (coin rejected mid-hold).
    vq.push_back(mk(0,0,0, 2,0,0, 2'b01, 12'h000, 12'h000, 8'h30, 0, 0, 0, 0));
    vq.push_back(mk(0,0,1, 2,0,0, 2'b10, 12'h010, 12'h000, 8'h30, 0, 0, 0, 0));
    vq.push_back(mk(0,0,1, 2,0,0, 2'b10, 12'h020, 12'h000, 8'h30, 0, 0, 0, 0));
    vq.push_back(mk(0,0,1, 2,0,0, 2'b10, 12'h030, 12'h000, 8'h30, 0, 0, 0, 0));
    vq.push_back(mk(0,1,0, 2,0,0, 2'b10, 12'h035, 12'h000, 8'h30, 0, 0, 0, 0));
    vq.push_back(mk(0,0,0, 2,1,0, 2'b11, 12'h035, 12'h000, 8'h30, 1, 2, 0, 0));
    vq.push_back(mk(0,0,0, 2,0,0, 2'b00, 12'h000, 12'h005, 8'h30, 0, 2, 0, 0));
    vq.push_back(mk(0,0,0, 2,0,0, 2'b00, 12'h000, 12'h005, 8'h30, 0, 2, 0, 0));
    vq.push_back(mk(0,0,1, 2,1,1, 2'b00, 12'h000, 12'h005, 8'h30, 0, 2, 1, 0));
    for (int i = 0; i < 5; i++)
      vq.push_back(mk(0,0,0, 2,0,0, 2'b00, 12'h000, 12'h005, 8'h30, 0, 2, 0, 0));
    vq.push_back(mk(0,0,0, 2,0,0, 2'b01, 12'h000, 12'h000, 8'h30, 0, 2, 0, 0));
    // Item 3: insufficient credit, then cancel refunds 40.
    vq.push_back(mk(0,0,0, 3,0,0, 2'b01, 12'h000, 12'h000, 8'h45, 0, 2, 0, 0));
    vq.push_back(mk(0,0,1, 3,0,0, 2'b10, 12'h010, 12'h000, 8'h45, 0, 2, 0, 0));
    vq.push_back(mk(0,0,1, 3,0,0, 2'b10, 12'h020, 12'h000, 8'h45, 0, 2, 0, 0));
    vq.push_back(mk(0,0,1, 3,0,0, 2'b10, 12'h030, 12'h000, 8'h45, 0, 2, 0, 0));
    vq.push_back(mk(0,0,1, 3,0,0, 2'b10, 12'h040, 12'h000, 8'h45, 0, 2, 0, 0));
    vq.push_back(mk(0,0,0, 3,1,0, 2'b10, 12'h040, 12'h000, 8'h45, 0, 2, 0, 1));
    vq.push_back(mk(0,0,0, 3,0,0, 2'b10, 12'h040, 12'h000, 8'h45, 0, 2, 0, 0));
    vq.push_back(mk(0,0,0, 3,0,1, 2'b00, 12'h000, 12'h040, 8'h45, 0, 2, 0, 0));
    for (int i = 0; i < 7; i++)
      vq.push_back(mk(0,0,0, 3,0,0, 2'b00, 12'h000, 12'h040, 8'h45, 0, 2, 0, 0));
    vq.push_back(mk(0,0,0, 3,0,0, 2'b01, 12'h000, 12'h000, 8'h45, 0, 2, 0, 0));

    @(negedge clk);
    @(negedge clk);
    chk("reset state",   {30'd0, state}, 32'h1);
    chk("reset money",   {20'd0, money}, 32'h0);
    chk("reset change",  {20'd0, small_change}, 32'h0);
    chk("reset gm",      {24'd0, goods_money}, 32'h15);
    chk("reset pulses",  {29'd0, dispense, coin_reject, buy_err}, 32'h0);
    chk("reset gout",    {30'd0, goods_out}, 32'h0);
    rst = 1'b1;

    for (int i = 0; i < vq.size(); i++) begin
      step(vq[i].c1, vq[i].c5, vq[i].c10, vq[i].sel, vq[i].b, vq[i].cn);
      chk($sformatf("row%0d state", i),  {30'd0, state}, {30'd0, vq[i].st});
      chk($sformatf("row%0d money", i),  {20'd0, money}, {20'd0, vq[i].m});
      chk($sformatf("row%0d change", i), {20'd0, small_change}, {20'd0, vq[i].ch});
      chk($sformatf("row%0d gm", i),     {24'd0, goods_money}, {24'd0, vq[i].gm});
      chk($sformatf("row%0d disp", i),   {31'd0, dispense}, {31'd0, vq[i].disp});
      chk($sformatf("row%0d gout", i),   {30'd0, goods_out}, {30'd0, vq[i].gout});
      chk($sformatf("row%0d rej", i),    {31'd0, coin_reject}, {31'd0, vq[i].rej});
      chk($sformatf("row%0d err", i),    {31'd0, buy_err}, {31'd0, vq[i].err});
    end

    // Carry chain 099 -> 100 -> 116, then cancel racing a coin.
    for (int i = 0; i < 9; i++) step(0, 0, 1, 3, 0, 0);
    step(0, 1, 0, 3, 0, 0);
    for (int i = 0; i < 4; i++) step(1, 0, 0, 3, 0, 0);
    chk("carry 099", {20'd0, money}, 32'h099);
    step(1, 0, 0, 3, 0, 0);
    chk("carry 100", {20'd0, money}, 32'h100);
    step(1, 1, 1, 3, 0, 0);
    chk("multi coin 116", {20'd0, money}, 32'h116);
    step(0, 1, 0, 3, 0, 1);
    chk("cancel+coin rej",    {31'd0, coin_reject}, 32'h1);
    chk("cancel+coin refund", {20'd0, small_change}, 32'h116);
    chk("cancel+coin money",  {20'd0, money}, 32'h0);
    chk("cancel+coin state",  {30'd0, state}, 32'h0);
    wait_idle("hold expiry after cancel");

    // Saturation at 995.
    for (int i = 0; i < 99; i++) step(0, 0, 1, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0);
    chk("sat 995", {20'd0, money}, 32'h995);
    step(0, 0, 1, 0, 0, 0);
    chk("sat reject", {31'd0, coin_reject}, 32'h1);
    chk("sat hold",   {20'd0, money}, 32'h995);
    step(1, 0, 0, 0, 0, 0);
    chk("sat 996",     {20'd0, money}, 32'h996);
    chk("sat rej off", {31'd0, coin_reject}, 32'h0);

    // Reset asserted while in VEND.
    step(0, 0, 0, 0, 1, 0);
    chk("vend state", {30'd0, state}, 32'h3);
    chk("vend disp",  {31'd0, dispense}, 32'h1);
    rst = 1'b0;
    #1;
    chk("rst vend state", {30'd0, state}, 32'h1);
    chk("rst vend disp",  {31'd0, dispense}, 32'h0);
    chk("rst vend money", {20'd0, money}, 32'h0);
    chk("rst vend gm",    {24'd0, goods_money}, 32'h15);
    @(negedge clk);
    rst = 1'b1;
    step(0, 0, 0, 0, 0, 0);
    chk("post rst disp",   {31'd0, dispense}, 32'h0);
    chk("post rst state",  {30'd0, state}, 32'h1);
    chk("post rst change", {20'd0, small_change}, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/vend_ctrl.md
Name: vend_ctrl

Overview:
- Vending-machine transaction controller.
- Sits directly upstream of the seven-segment display driver and produces its goods_money, money, small_change and state inputs.
- Accumulates coin pulses in BCD, looks up the selected item's price, validates purchases and computes change.
- All arithmetic is packed BCD, so the display stage consumes the outputs nibble-for-nibble.

Parameters:
- PRICE0, 8'h15, BCD price of item 0
- PRICE1, 8'h25, BCD price of item 1
- PRICE2, 8'h30, BCD price of item 2
- PRICE3, 8'h45, BCD price of item 3
- HOLD_CYCLES, 32'd50_000_000, clock cycles the CHANGE state is held before returning to IDLE (must be >= 1)

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-low reset
- coin_1  in  1  one-cycle pulse, 1-unit coin inserted
- coin_5  in  1  one-cycle pulse, 5-unit coin inserted
- coin_10  in  1  one-cycle pulse, 10-unit coin inserted
- goods_sel  in  2  item select, indexes PRICE0..3
- buy  in  1  one-cycle purchase request
- cancel  in  1  one-cycle refund request
- goods_money  out  8  BCD price of the selected item
- money  out  12  BCD credit inserted
- small_change  out  12  BCD change or refund
- state  out  2  01 IDLE, 10 PAY, 11 VEND, 00 CHANGE
- dispense  out  1  one-cycle pulse, item released
- goods_out  out  2  item index released, valid with dispense
- coin_reject  out  1  one-cycle pulse, coin(s) returned
- buy_err  out  1  one-cycle pulse, buy with insufficient credit

Behaviour:
- Reset (rst low, async):
  - state=01, money=0, small_change=0, goods_money=PRICE0, goods_out=0.
  - dispense, coin_reject, buy_err = 0; hold counter = 0.
- All outputs are registered. Pulse outputs are high for exactly one cycle.
- goods_money:
  - Registered from PRICE[goods_sel] every cycle in IDLE and PAY (1-cycle latency).
  - Frozen in VEND and CHANGE.
- Coin value for a cycle = 1*coin_1 + 5*coin_5 + 10*coin_10. Multiple simultaneous pulses are summed (max 16).
- Coin acceptance (IDLE/PAY):
  - money <= BCD(money + value), applied the next cycle.
  - If the sum exceeds 999, money is unchanged and coin_reject pulses.
  - Every BCD digit of money is always 0-9.
- IDLE (01):
  - An accepted coin -> PAY.
  - buy and cancel are ignored (no buy_err).
- PAY (10), priority order cancel > coin > buy:
  - cancel: small_change <= money, money <= 0, go to CHANGE. A coin in the same cycle is rejected (coin_reject).
  - Coin with no cancel: added as above; a buy in the same cycle is ignored.
  - buy alone with money >= PRICE[goods_sel] (BCD compare, price zero-extended to 12 bits): latch goods_sel, go to VEND.
  - buy alone with money < price: buy_err pulses, stay in PAY.
- VEND (11), exactly one cycle:
  - dispense=1, goods_out=latched index.
  - small_change <= BCD(money - price) using the latched price.
  - money <= 0, go to CHANGE.
  - Coins are rejected.
- CHANGE (00):
  - Hold counter counts HOLD_CYCLES cycles.
  - Coins are rejected; buy and cancel are ignored.
  - On expiry: small_change <= 0, counter cleared, go to IDLE.
  - Zero change still holds the full time.
- BCD subtract: per-digit borrow with 10s-complement correction. The result is never negative because VEND is only entered when money >= price.
- Reset mid-operation returns to the reset state: pending credit is lost and no dispense occurs.

Test Plan:
- Reset -> state=01, money=000, small_change=000, goods_money=15, all pulses 0.
- goods_sel=2, then coin_10, coin_10, coin_10, coin_5 on separate cycles -> money=035, state=10. Then buy -> state=11 for one cycle, dispense=1, goods_out=2, small_change=005, money=000. After HOLD_CYCLES (bench overrides to 8) -> state=01, small_change=000.
- goods_sel=3, money=040, buy -> buy_err one cycle, state stays 10, money=040. Then cancel -> small_change=040, state=00.
- Carry chain: money=099, then coin_1 -> money=100. Then coin_1+coin_5+coin_10 in one cycle -> money=116.
- Saturation: money=995, coin_10 -> coin_reject=1, money stays 995. Then coin_1 -> money=996.
- Simultaneous cancel+coin_5 in PAY -> coin_reject=1, refund equals the prior money. A coin during CHANGE -> coin_reject=1 and money unchanged. Reset asserted in VEND -> no dispense, state=01.
